// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: occupancy state encoding and default bubble fill bit.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } occ_state_t;

  localparam logic PIPE_BUBBLE_BIT = 1'b0;

endpackage

// File: rtl/pipe_skid_entry.sv
// Skid holding register: valid + payload with load and clear (clear wins); one-cycle update.
module pipe_skid_entry #(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] din,
  output logic              vld,
  output logic [DATA_W-1:0] dat
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= 1'b0;
      dat <= BUBBLE_VAL;
    end else if (clear) begin
      vld <= 1'b0;
      dat <= BUBBLE_VAL;
    end else if (load) begin
      vld <= 1'b1;
      dat <= din;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register, 1-cycle latency; PIPE_SKID_REG_SKID_EN adds a skid entry for full throughput.
// Backpressure: output held while OUT_READY low; IN_READY registered with skid, else OUT_READY || !OUT_VALID.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{PIPE_BUBBLE_BIT}}
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [1:0]        OCC
);

  occ_state_t        state, state_nxt;
  logic              in_fire, out_fire, main_load;
  logic [DATA_W-1:0] main_dat, main_nxt_dat;
`ifdef PIPE_SKID_REG_SKID_EN
  logic              skid_load, skid_clear, skid_vld, in_rdy_q;
  logic [DATA_W-1:0] skid_dat;
`endif

  assign in_fire  = IN_VALID && IN_READY;
  assign out_fire = OUT_VALID && OUT_READY;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    main_load    = 1'b0;
    main_nxt_dat = IN_DATA;
`ifdef PIPE_SKID_REG_SKID_EN
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
`endif
    if (FLUSH) begin
      state_nxt = EMPTY;
`ifdef PIPE_SKID_REG_SKID_EN
      skid_clear = 1'b1;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = BUSY;
            main_load = 1'b1;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (out_fire) begin
            state_nxt = EMPTY;
`ifdef PIPE_SKID_REG_SKID_EN
          end else if (in_fire) begin
            state_nxt = FULL;
            skid_load = 1'b1;
`endif
          end
        end
`ifdef PIPE_SKID_REG_SKID_EN
        FULL: begin
          // IN_READY is low here, so the only move is skid -> main
          if (out_fire && skid_vld) begin
            state_nxt    = BUSY;
            main_load    = 1'b1;
            main_nxt_dat = skid_dat;
            skid_clear   = 1'b1;
          end
        end
`endif
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)          main_dat <= BUBBLE_VAL;
    else if (main_load) main_dat <= main_nxt_dat;
  end

`ifdef PIPE_SKID_REG_SKID_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) in_rdy_q <= 1'b1;
    else       in_rdy_q <= (state_nxt != FULL);
  end

  pipe_skid_entry #(
    .DATA_W     (DATA_W),
    .BUBBLE_VAL (BUBBLE_VAL)
  ) u_skid (
    .clk   (CLK),
    .rst   (RESET),
    .load  (skid_load),
    .clear (skid_clear),
    .din   (IN_DATA),
    .vld   (skid_vld),
    .dat   (skid_dat)
  );
`endif

  always_comb begin
    OUT_VALID = (state != EMPTY);
    OUT_DATA  = (state != EMPTY) ? main_dat : BUBBLE_VAL;
    OCC       = state;
`ifdef PIPE_SKID_REG_SKID_EN
    IN_READY  = in_rdy_q;
`else
    IN_READY  = OUT_READY || (state == EMPTY);
`endif
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg; expectations follow PIPE_SKID_REG_SKID_EN when defined.
module tb_pipe_skid_reg;

  localparam int                DATA_W = 64;
  localparam logic [DATA_W-1:0] BUBBLE = '0;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready, out_valid;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occ;

  int vectors = 0;
  int miscompares = 0;
  logic [DATA_W-1:0] exp_q[$];
  int m_occ = 0;
  int acc_cnt = 0;
  int emit_cnt = 0;
  logic m_rdy;

  pipe_skid_reg #(
    .DATA_W     (DATA_W),
    .BUBBLE_VAL (BUBBLE)
  ) dut (
    .CLK       (clk),
    .RESET     (rst),
    .FLUSH     (flush),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .IN_DATA   (in_data),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .OUT_DATA  (out_data),
    .OCC       (occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor + acceptance model, sampled mid-cycle while inputs are stable
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_occ = 0;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_occ", occ, 2'd0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_data", out_data, BUBBLE);
    end else begin
`ifdef PIPE_SKID_REG_SKID_EN
      m_rdy = (m_occ != 2);
`else
      m_rdy = out_ready || (m_occ == 0);
`endif
      chk("occ", occ, m_occ);
      chk("in_ready", in_ready, m_rdy);
      chk("out_valid", out_valid, (m_occ != 0));
      if (m_occ == 0) chk("bubble", out_data, BUBBLE);
      else            chk("out_data", out_data, exp_q[0]);
      if (flush) begin
        exp_q.delete();
        m_occ = 0;
      end else begin
        if (m_occ != 0 && out_ready) begin
          void'(exp_q.pop_front());
          emit_cnt++;
          m_occ--;
        end
        if (in_valid && m_rdy) begin
          exp_q.push_back(in_data);
          acc_cnt++;
          m_occ++;
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, emit0;
    #1 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_occ", occ, 2'd0);
    chk("async_rst_in_ready", in_ready, 1'b1);
    chk("async_rst_out_data", out_data, BUBBLE);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // basic pass-through
    drive(1'b1, 64'h0000_0004_0000_0013, 1'b1, 1'b0);
    chk("pass_out_valid", out_valid, 1'b1);
    chk("pass_out_data", out_data, 64'h0000_0004_0000_0013);
    chk("pass_occ", occ, 2'd1);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("pass_drain_occ", occ, 2'd0);

    // back-pressure
`ifdef PIPE_SKID_REG_SKID_EN
    drive(1'b1, 64'hA, 1'b0, 1'b0);
    drive(1'b1, 64'hB, 1'b0, 1'b0);
    chk("bp_occ_full", occ, 2'd2);
    chk("bp_in_ready_full", in_ready, 1'b0);
    chk("bp_hold_a", out_data, 64'hA);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_registered", in_ready, 1'b0);
    out_ready = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("bp_still_a", out_data, 64'hA);
    chk("bp_still_valid", out_valid, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("bp_then_b", out_data, 64'hB);
    chk("bp_occ_one", occ, 2'd1);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("bp_occ_zero", occ, 2'd0);
`else
    drive(1'b1, 64'hA, 1'b0, 1'b0);
    chk("ns_occ_one", occ, 2'd1);
    in_valid = 1'b0;
    #1;
    chk("ns_in_ready_low", in_ready, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("ns_in_ready_comb", in_ready, 1'b1);
    out_ready = 1'b0;
    drive(1'b1, 64'hB, 1'b0, 1'b0);
    chk("ns_hold_a", out_data, 64'hA);
    chk("ns_occ_max", occ, 2'd1);
    drive(1'b1, 64'hB, 1'b1, 1'b0);
    chk("ns_swap_b", out_data, 64'hB);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("ns_occ_zero", occ, 2'd0);
`endif

    // flush beats a simultaneous input transfer
    drive(1'b1, 64'h1A, 1'b0, 1'b0);
`ifdef PIPE_SKID_REG_SKID_EN
    drive(1'b1, 64'h1B, 1'b0, 1'b0);
    chk("flush_pre_occ", occ, 2'd2);
`endif
    drive(1'b1, 64'hC, 1'b0, 1'b1);
    chk("flush_occ", occ, 2'd0);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_out_data", out_data, BUBBLE);
    chk("flush_in_ready", in_ready, 1'b1);
    drive(1'b1, 64'hD, 1'b0, 1'b1);
    chk("flush_empty_drop", occ, 2'd0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);

    // async reset between edges
    drive(1'b1, 64'h2A, 1'b0, 1'b0);
`ifdef PIPE_SKID_REG_SKID_EN
    drive(1'b1, 64'h2B, 1'b0, 1'b0);
    chk("rst_pre_occ", occ, 2'd2);
`endif
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_occ", occ, 2'd0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_data", out_data, BUBBLE);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b0);

    // streaming with random downstream stalls
    acc0 = acc_cnt;
    emit0 = emit_cnt;
    for (int c = 0; c < 3000 && (acc_cnt - acc0) < 100; c++) begin
      drive(1'b1, 64'h5000_0000_0000_0000 + 64'(acc_cnt - acc0), 1'($urandom_range(0, 1)), 1'b0);
    end
    for (int c = 0; c < 50 && m_occ != 0; c++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("stream_accepted", 64'(acc_cnt - acc0), 64'd100);
    chk("stream_emitted", 64'(emit_cnt - emit0), 64'd100);
    chk("stream_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("stream_end_occ", occ, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
